// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xoracc_pkg.sv
// Shared types and defaults for the XOR-accumulate arbiter slice.
package gf180mcu_fd_sc_mcu9t5v0__xoracc_pkg;

  localparam int unsigned XORACC_NREQ  = 4;
  localparam int unsigned XORACC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    RESULT = 2'd2
  } xoracc_state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping modulo NREQ.
module gf180mcu_fd_sc_mcu9t5v0__rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            valid_o
);

  localparam int unsigned SW = IDW + 1;

  logic [SW-1:0]  sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      // One extra bit lets the wrap work for non-power-of-two NREQ.
      sum = {1'b0, ptr_i} + SW'(off);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o       = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xoracc_arb.sv
// Round-robin arbiter sharing one XOR-accumulate datapath between NREQ burst requesters.
// Optional RES_PAR output enabled by GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN.
module gf180mcu_fd_sc_mcu9t5v0__xoracc_arb
  import gf180mcu_fd_sc_mcu9t5v0__xoracc_pkg::*;
#(
  parameter int unsigned NREQ  = XORACC_NREQ,
  parameter int unsigned WIDTH = XORACC_WIDTH,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ-1:0]       REQ_LAST,
  input  logic [NREQ*WIDTH-1:0] REQ_DATA,
  output logic [NREQ-1:0]       REQ_READY,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [WIDTH-1:0]      RES_DATA,
  output logic [IDW-1:0]        RES_ID,
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
  output logic                  RES_PAR,
`endif
  output logic                  BUSY
);

  xoracc_state_e    state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   gnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [NREQ-1:0]  rdy_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [IDW-1:0]   res_id_q;
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
  logic             par_q;
`endif

  logic [NREQ-1:0]  pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] data_a [NREQ];
  logic             xfer;

  for (genvar i = 0; i < NREQ; i++) begin : g_data
    assign data_a[i] = REQ_DATA[i*WIDTH +: WIDTH];
  end

  gf180mcu_fd_sc_mcu9t5v0__rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i     (REQ_VALID),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .valid_o   (pick_any)
  );

  // rdy_q is only ever non-zero in ACC, so it doubles as the state qualifier.
  assign xfer  = REQ_VALID[gnt_q] & rdy_q[gnt_q];
  assign acc_d = acc_q ^ data_a[gnt_q];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      acc_q       <= '0;
      rdy_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q   <= pick_idx;
            acc_q   <= '0;
            rdy_q   <= pick_oh;
            state_q <= ACC;
          end
        end
        ACC: begin
          if (xfer) begin
            acc_q <= acc_d;
            if (REQ_LAST[gnt_q]) begin
              res_data_q  <= acc_d;
              res_id_q    <= gnt_q;
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
              par_q       <= ^acc_d;
`endif
              res_valid_q <= 1'b1;
              rdy_q       <= '0;
              state_q     <= RESULT;
            end
          end
        end
        RESULT: begin
          if (RES_READY) begin
            res_valid_q <= 1'b0;
            ptr_q       <= (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign REQ_READY = rdy_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_ID    = res_id_q;
  assign BUSY      = (state_q != IDLE);
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
  assign RES_PAR   = par_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__xoracc_arb.sv
// Self-checking bench for the XOR-accumulate arbiter; expected results flow through a scoreboard queue.
module tb_gf180mcu_fd_sc_mcu9t5v0__xoracc_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NREQ-1:0]       REQ_VALID;
  logic [NREQ-1:0]       REQ_LAST;
  logic [NREQ*WIDTH-1:0] REQ_DATA;
  logic [NREQ-1:0]       REQ_READY;
  logic                  RES_VALID;
  logic                  RES_READY;
  logic [WIDTH-1:0]      RES_DATA;
  logic [IDW-1:0]        RES_ID;
  logic                  BUSY;
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
  logic                  RES_PAR;
`endif

  gf180mcu_fd_sc_mcu9t5v0__xoracc_arb #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_LAST  (REQ_LAST),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_DATA  (RES_DATA),
    .RES_ID    (RES_ID),
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
    .RES_PAR   (RES_PAR),
`endif
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [WIDTH-1:0] exp_d [$];
  logic [IDW-1:0]   exp_i [$];
  logic [WIDTH-1:0] bq    [$];
  logic [WIDTH-1:0] ed;
  logic [IDW-1:0]   ei;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic [IDW-1:0] id);
    exp_d.push_back(d);
    exp_i.push_back(id);
  endtask

  // Drives the beats in bq on requester r, optionally dropping VALID for gap_len
  // cycles before beat gap_at. Returns right after the last beat has transferred.
  task automatic drive_burst(input int r, input int gap_at, input int gap_len);
    int k = 0;
    int g = 0;
    int guard = 0;
    while (k < bq.size() && guard < 200) begin
      if (k == gap_at && g < gap_len) begin
        REQ_VALID[r] = 1'b0;
        g++;
      end else begin
        REQ_VALID[r] = 1'b1;
        REQ_DATA[r*WIDTH +: WIDTH] = bq[k];
        REQ_LAST[r] = (k == bq.size() - 1);
        if (REQ_READY[r]) k++;
      end
      tick();
      guard++;
    end
    REQ_VALID[r] = 1'b0;
    REQ_LAST[r]  = 1'b0;
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL burst_timeout req=%0d beats_done=%0d required=%0d", r, k, bq.size());
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    REQ_VALID = '0;
    REQ_LAST  = '0;
    REQ_DATA  = '0;
    RES_READY = 1'b0;
    do_reset();
    total++; if (REQ_READY !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", REQ_READY); end
    total++; if (RES_VALID !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", RES_VALID); end
    total++; if (RES_DATA !== 8'h00) begin bad++; $display("FAIL rst_res_data got=%h exp=00", RES_DATA); end
    total++; if (RES_ID !== 2'd0) begin bad++; $display("FAIL rst_res_id got=%0d exp=0", RES_ID); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
    total++; if (RES_PAR !== 1'b0) begin bad++; $display("FAIL rst_res_par got=%b exp=0", RES_PAR); end
`endif
  endtask

  task automatic test_single_burst();
    int start;
    RES_READY = 1'b1;
    bq = '{8'h0F, 8'hF0, 8'h55, 8'h00};
    push_exp(8'hAA, 2'd1);
    start = cyc;
    REQ_VALID[1] = 1'b1;
    REQ_DATA[1*WIDTH +: WIDTH] = 8'h0F;
    tick();
    total++; if (REQ_READY !== 4'b0010) begin bad++; $display("FAIL grant_latency got=%b exp=0010", REQ_READY); end
    drive_burst(1, 99, 0);
    ed = exp_d.pop_front();
    ei = exp_i.pop_front();
    total++; if (RES_VALID !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", RES_VALID); end
    total++; if (RES_DATA !== ed) begin bad++; $display("FAIL single_data got=%h exp=%h", RES_DATA, ed); end
    total++; if (RES_ID !== ei) begin bad++; $display("FAIL single_id got=%0d exp=%0d", RES_ID, ei); end
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
    total++; if (RES_PAR !== ^ed) begin bad++; $display("FAIL single_par got=%b exp=%b", RES_PAR, ^ed); end
`endif
    tick();
    total++; if (RES_VALID !== 1'b0) begin bad++; $display("FAIL single_valid_pulse got=%b exp=0", RES_VALID); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", BUSY); end
    total++; if (cyc - start !== 6) begin bad++; $display("FAIL single_turnaround got=%0d exp=6", cyc - start); end
  endtask

  task automatic test_round_robin();
    int results = 0;
    int guard = 0;
    do_reset();
    RES_READY = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(8'h10 + 8'(i % 4), 2'(i % 4));
    for (int i = 0; i < NREQ; i++) REQ_DATA[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
    REQ_LAST  = '1;
    REQ_VALID = '1;
    while (results < 5 && guard < 100) begin
      tick();
      guard++;
      total++; if ($countones(REQ_READY) > 1) begin bad++; $display("FAIL rr_onehot got=%b exp=onehot_or_zero", REQ_READY); end
      if (RES_VALID) begin
        ed = exp_d.pop_front();
        ei = exp_i.pop_front();
        total++; if (RES_ID !== ei) begin bad++; $display("FAIL rr_order got=%0d exp=%0d", RES_ID, ei); end
        total++; if (RES_DATA !== ed) begin bad++; $display("FAIL rr_data got=%h exp=%h", RES_DATA, ed); end
        results++;
        if (results == 5) REQ_VALID = '0;
      end
    end
    REQ_VALID = '0;
    REQ_LAST  = '0;
    if (guard >= 100) begin total++; bad++; $display("FAIL rr_timeout got=%0d exp=5", results); end
    tick();
  endtask

  task automatic test_backpressure();
    RES_READY = 1'b0;
    bq = '{8'h12, 8'h34};
    push_exp(8'h26, 2'd0);
    ed = exp_d[0];
    drive_burst(0, 99, 0);
    REQ_VALID[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total++; if (RES_VALID !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, RES_VALID); end
      total++; if (RES_DATA !== ed) begin bad++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, RES_DATA, ed); end
      total++; if (REQ_READY !== 4'b0000) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, REQ_READY); end
      total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL bp_busy c=%0d got=%b exp=1", c, BUSY); end
      tick();
    end
    REQ_VALID[2] = 1'b0;
    RES_READY = 1'b1;
    ed = exp_d.pop_front();
    ei = exp_i.pop_front();
    total++; if (RES_ID !== ei) begin bad++; $display("FAIL bp_id got=%0d exp=%0d", RES_ID, ei); end
    tick();
    total++; if (RES_VALID !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", RES_VALID); end
  endtask

  task automatic test_bubbles();
    RES_READY = 1'b1;
    bq = '{8'h01, 8'h03};
    push_exp(8'h02, 2'd2);
    drive_burst(2, 1, 3);
    ed = exp_d.pop_front();
    ei = exp_i.pop_front();
    total++; if (RES_VALID !== 1'b1) begin bad++; $display("FAIL bub_valid got=%b exp=1", RES_VALID); end
    total++; if (RES_DATA !== ed) begin bad++; $display("FAIL bub_data got=%h exp=%h", RES_DATA, ed); end
    total++; if (RES_ID !== ei) begin bad++; $display("FAIL bub_id got=%0d exp=%0d", RES_ID, ei); end
    tick();
  endtask

  task automatic test_reset_mid();
    int results = 0;
    int guard = 0;
    RES_READY = 1'b1;
    REQ_VALID[1] = 1'b1;
    REQ_LAST[1]  = 1'b0;
    REQ_DATA[1*WIDTH +: WIDTH] = 8'h11;
    tick();
    tick();
    REQ_DATA[1*WIDTH +: WIDTH] = 8'h22;
    tick();
    REQ_DATA[1*WIDTH +: WIDTH] = 8'h33;
    RST = 1'b1;
    REQ_VALID = '0;
    tick();
    RST = 1'b0;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", BUSY); end
    total++; if (REQ_READY !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000", REQ_READY); end
    total++; if (RES_DATA !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h exp=00", RES_DATA); end
    total++; if (RES_VALID !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", RES_VALID); end
    // Requesters 0 and 3 contend; a cleared pointer must serve 0 first.
    push_exp(8'h3C, 2'd0);
    push_exp(8'h77, 2'd3);
    REQ_DATA[0*WIDTH +: WIDTH] = 8'h3C;
    REQ_DATA[3*WIDTH +: WIDTH] = 8'h77;
    REQ_LAST  = 4'b1001;
    REQ_VALID = 4'b1001;
    while (results < 2 && guard < 100) begin
      tick();
      guard++;
      if (RES_VALID) begin
        ed = exp_d.pop_front();
        ei = exp_i.pop_front();
        total++; if (RES_ID !== ei) begin bad++; $display("FAIL mid_post_id got=%0d exp=%0d", RES_ID, ei); end
        total++; if (RES_DATA !== ed) begin bad++; $display("FAIL mid_post_data got=%h exp=%h", RES_DATA, ed); end
        REQ_VALID[ei] = 1'b0;
        results++;
      end
    end
    REQ_VALID = '0;
    REQ_LAST  = '0;
    if (guard >= 100) begin total++; bad++; $display("FAIL mid_post_timeout got=%0d exp=2", results); end
    tick();
  endtask

  task automatic test_single_beat_foreign_last();
    int guard = 0;
    bit seen = 1'b0;
    RES_READY = 1'b1;
    do_reset();
    // Pointer moved to 1 after serving requester 0, so 3 wins over 0.
    bq = '{8'h99};
    push_exp(8'h99, 2'd0);
    drive_burst(0, 99, 0);
    ed = exp_d.pop_front();
    ei = exp_i.pop_front();
    total++; if (RES_DATA !== ed) begin bad++; $display("FAIL sb_pre_data got=%h exp=%h", RES_DATA, ed); end
    push_exp(8'h81, 2'd3);
    REQ_DATA[0*WIDTH +: WIDTH] = 8'hFF;
    REQ_DATA[3*WIDTH +: WIDTH] = 8'h81;
    REQ_LAST[3]  = 1'b1;
    REQ_VALID[3] = 1'b1;
    REQ_VALID[0] = 1'b1;
    while (!seen && guard < 50) begin
      REQ_LAST[0] = ~REQ_LAST[0];
      tick();
      guard++;
      total++; if (REQ_READY[0] !== 1'b0) begin bad++; $display("FAIL sb_req0_ready got=%b exp=0", REQ_READY[0]); end
      if (RES_VALID) begin
        seen = 1'b1;
        REQ_VALID = '0;
        ed = exp_d.pop_front();
        ei = exp_i.pop_front();
        total++; if (RES_DATA !== ed) begin bad++; $display("FAIL sb_data got=%h exp=%h", RES_DATA, ed); end
        total++; if (RES_ID !== ei) begin bad++; $display("FAIL sb_id got=%0d exp=%0d", RES_ID, ei); end
      end
    end
    REQ_VALID = '0;
    REQ_LAST  = '0;
    if (!seen) begin total++; bad++; $display("FAIL sb_timeout got=no_result exp=result"); end
    tick();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL sb_busy_end got=%b exp=0", BUSY); end
  endtask

  task automatic test_back_to_back();
    int r;
    int n;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] v;
    RES_READY = 1'b1;
    for (int b = 0; b < 8; b++) begin
      r = $urandom_range(0, NREQ - 1);
      n = $urandom_range(1, 5);
      bq.delete();
      x = '0;
      for (int k = 0; k < n; k++) begin
        v = WIDTH'($urandom);
        bq.push_back(v);
        x = x ^ v;
      end
      push_exp(x, 2'(r));
      drive_burst(r, (b % 2 == 0) ? 99 : 1, 2);
      ed = exp_d.pop_front();
      ei = exp_i.pop_front();
      total++; if (RES_VALID !== 1'b1) begin bad++; $display("FAIL b2b_valid b=%0d got=%b exp=1", b, RES_VALID); end
      total++; if (RES_DATA !== ed) begin bad++; $display("FAIL b2b_data b=%0d got=%h exp=%h", b, RES_DATA, ed); end
      total++; if (RES_ID !== ei) begin bad++; $display("FAIL b2b_id b=%0d got=%0d exp=%0d", b, RES_ID, ei); end
`ifdef GF180MCU_FD_SC_MCU9T5V0_XORACC_PARITY_EN
      total++; if (RES_PAR !== ^ed) begin bad++; $display("FAIL b2b_par b=%0d got=%b exp=%b", b, RES_PAR, ^ed); end
`endif
    end
    tick();
  endtask

  initial begin
    RST       = 1'b1;
    REQ_VALID = '0;
    REQ_LAST  = '0;
    REQ_DATA  = '0;
    RES_READY = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_single_beat_foreign_last();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
